// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch state encoding and the
// instruction length rule used by both fetch and decode.
package cpu_pkg;

   // Loads (2-byte: opcode, address)
   localparam logic [7:0] YUKLE_A     = 8'h86;
   localparam logic [7:0] YUKLE_B     = 8'h87;
   localparam logic [7:0] YUKLE_C     = 8'h88;
   localparam logic [7:0] YUKLE_D     = 8'h89;
   // Stores (2-byte: opcode, address)
   localparam logic [7:0] KAYDET_A    = 8'h96;
   localparam logic [7:0] KAYDET_B    = 8'h97;
   // Arithmetic / logic (1-byte)
   localparam logic [7:0] BOS         = 8'h00;
   localparam logic [7:0] TOPLA       = 8'h42;
   localparam logic [7:0] CIKAR       = 8'h43;
   localparam logic [7:0] VE          = 8'h44;
   localparam logic [7:0] VEYA        = 8'h45;
   localparam logic [7:0] DEGIL       = 8'h46;
   localparam logic [7:0] SOLA_KAYDIR = 8'h47;
   localparam logic [7:0] SAGA_KAYDIR = 8'h48;
   localparam logic [7:0] KARSILASTIR = 8'h49;
   // Jumps (2-byte: opcode, target)
   localparam logic [7:0] ATLA        = 8'h20;
   localparam logic [7:0] ATLA_SIFIR  = 8'h21;
   localparam logic [7:0] ATLA_DEGIL  = 8'h22;
   localparam logic [7:0] ATLA_ELDE   = 8'h23;
   localparam logic [7:0] ATLA_SON    = 8'h28;

   // Fetch state encoding
   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_OP    = 3'd1;
   localparam logic [2:0] ST_OPR   = 3'd2;
   localparam logic [2:0] ST_ISSUE = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // Loads, stores and jumps carry an operand byte; everything else,
   // including unknown opcodes, is a single byte.
   function automatic logic is_two_byte(input logic [7:0] opcode);
      return (opcode[7:4] == 4'h8) || (opcode[7:4] == 4'h9) ||
             (opcode[7:4] == 4'h2);
   endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational instruction length decode, shared by fetch and decode.
module instr_len_decode
   import cpu_pkg::*;
(
   input  logic [7:0] opcode,
   output logic       len
);

   // 1 = opcode is followed by an operand byte
   assign len = is_two_byte(opcode);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the ROM with a fetch pointer, absorbs the ROM's
// one-cycle read latency, and hands complete instructions to the decoder.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int ROM_DEPTH = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        instr_opcode,
   output logic [7:0]        instr_operand,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_len,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              halted
);

   // ROM depth at one extra bit so a carry out of the PC reads as out of range
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(ROM_DEPTH);

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] fp;
   logic [7:0]        opcode_q;
   logic [7:0]        operand_q;
   logic [ADDR_W-1:0] pc_q;
   logic              len_q;
   logic              dec_len;
   logic [ADDR_W:0]   next_pc;
   logic              operand_oob;
   logic              jump_oob;

   instr_len_decode u_len_decode (
      .opcode (mem_data),
      .len    (dec_len)
   );

   // Wide PC arithmetic: next instruction address and range checks
   assign next_pc     = {1'b0, pc} + (ADDR_W+1)'(1) + {{ADDR_W{1'b0}}, len_q};
   assign operand_oob = ({1'b0, pc} + (ADDR_W+1)'(1)) >= DEPTH_W;
   assign jump_oob    = {1'b0, jump_target} >= DEPTH_W;

   // Fetch FSM, PC/fetch-pointer registers and instruction output registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         pc        <= '0;
         fp        <= '0;
         opcode_q  <= 8'h00;
         operand_q <= 8'h00;
         pc_q      <= '0;
         len_q     <= 1'b0;
      end else if (jump_en) begin
         // Redirect wins over everything, including a same-cycle transfer
         pc    <= jump_target;
         fp    <= jump_target;
         state <= jump_oob ? ST_HALT : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: begin
               fp    <= pc + ADDR_W'(1);
               state <= ST_OP;
            end
            ST_OP: begin
               opcode_q <= mem_data;
               len_q    <= dec_len;
               pc_q     <= pc;
               if (dec_len) begin
                  state <= ST_OPR;
               end else begin
                  operand_q <= 8'h00;
                  state     <= ST_ISSUE;
               end
            end
            ST_OPR: begin
               // Operand past the end of the ROM is not real data
               operand_q <= operand_oob ? 8'h00 : mem_data;
               state     <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (instr_ready) begin
                  pc <= next_pc[ADDR_W-1:0];
                  if (next_pc >= DEPTH_W) begin
                     state <= ST_HALT;
                  end else begin
                     fp    <= next_pc[ADDR_W-1:0];
                     state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

   // Output decode
   assign mem_addr      = fp;
   assign instr_valid   = (state == ST_ISSUE);
   assign halted        = (state == ST_HALT);
   assign instr_opcode  = opcode_q;
   assign instr_operand = operand_q;
   assign instr_pc      = pc_q;
   assign instr_len     = len_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between `program_memory` and the instruction decoder.
- Drives the ROM address and captures opcode and operand bytes, accounting for the ROM's one-cycle registered read.
- Presents complete 1- or 2-byte instructions to the decoder over a valid/ready handshake.
- Accepts jump redirects from the execute stage and halts when the PC leaves the ROM address range.

## Interface
Parameters:
- `ADDR_W`, 8, width of PC and ROM address.
- `ROM_DEPTH`, 128, number of valid ROM locations. Addresses `>= ROM_DEPTH` are out of range.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_addr` output `ADDR_W`: address to `program_memory`. It is the fetch pointer register `fp`.
- `mem_data` input 8: ROM `data_out`. It is valid one cycle after `mem_addr` is presented.
- `instr_valid` output 1: the instruction output bus holds a complete instruction.
- `instr_ready` input 1: decoder accepts the instruction.
- `instr_opcode` output 8: opcode byte.
- `instr_operand` output 8: operand byte. It is 0x00 for 1-byte instructions.
- `instr_pc` output `ADDR_W`: address of the opcode byte.
- `instr_len` output 1: 0 = 1-byte instruction, 1 = 2-byte instruction.
- `jump_en` input 1: single-cycle redirect request.
- `jump_target` input `ADDR_W`: redirect address.
- `halted` output 1: fetch stopped because the PC is out of range.

## Operation
- Length decode:
  - Opcode high nibble 0x8, 0x9 or 0x2 is 2-byte. This covers loads 0x86–0x89, stores 0x96/0x97 and jumps 0x20–0x28.
  - Every other opcode is 1-byte. This covers ALU ops 0x42–0x49, 0x00 and unknown opcodes.
- States and transitions:
  - FETCH: `fp` = `pc`. Next state is OP, with `fp` <= `pc`+1.
  - OP: `mem_data` holds ROM[`pc`]. Latch it as the opcode. A 2-byte opcode goes to OPR. A 1-byte opcode goes to ISSUE with operand <= 0x00.
  - OPR: `mem_data` holds ROM[`pc`+1]. Latch it as the operand and go to ISSUE.
  - ISSUE: `instr_valid`=1. All `instr_*` outputs are held stable until `instr_ready`=1.
    - On transfer, `pc` <= `pc` + 1 + `instr_len`.
    - If the new `pc` is `>= ROM_DEPTH`, go to HALT. Otherwise go to FETCH.
  - HALT: `instr_valid`=0, `halted`=1. `fp` holds. Only a jump or a reset leaves this state.
- PC arithmetic:
  - The next PC is computed `ADDR_W`+1 bits wide. A carry out or a value `>= ROM_DEPTH` means out of range; there is never a silent wrap.
  - A 2-byte opcode at `ROM_DEPTH`-1: the operand is forced to 0x00, the instruction is still issued, then the block halts.
- Jump:
  - `jump_en` is sampled in every state. `pc` <= `jump_target` and any in-flight fetch or undelivered instruction is discarded.
  - Next state is FETCH, or HALT if `jump_target >= ROM_DEPTH`.
  - A jump has priority over a transfer in the same cycle. The transfer counts as completed, but the PC increment is ignored.
- Reset: `pc`=0, `fp`=0, state FETCH, `instr_valid`=0, `instr_opcode`/`instr_operand`/`instr_pc`=0, `instr_len`=0, `halted`=0.

## Timing
- After `rst_n` deasserts: FETCH in cycle 0, OP in cycle 1. `instr_valid` rises at cycle 2 for a 1-byte instruction and at cycle 3 for a 2-byte instruction.
- Steady state with `instr_ready`=1: 3 cycles per 1-byte instruction (FETCH, OP, ISSUE) and 4 cycles per 2-byte instruction.
- A jump in cycle N puts `instr_valid`=0 in N+1 and FETCH with `fp`=target in N+1. The first redirected instruction is valid at N+3 (1-byte) or N+4 (2-byte).
- Reset asserted in any state takes effect immediately. Outputs return to their reset values without waiting for a clock edge.
- `instr_valid` never drops without a transfer, jump or reset.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (YUKLE_*, KAYDET_*, arithmetic, ATLA_*), owned there rather than inside `program_memory`;
  - fetch state encoding;
  - `is_two_byte(opcode)` function, also reused by the decoder.
- Sub-module `instr_len_decode`: combinational, opcode in, `instr_len` out. It wraps `is_two_byte` so the decoder can instantiate the same logic.
- Top level: PC register, `fp` register, state register and instruction output registers.

## Test plan
- ROM program from address 0 (87 F0 89 F1 42 23 0B 96 80 20 20 87 F2 20 04), `instr_ready`=1, release reset:
  - (87,F0,pc 00,len 1) valid at cycle 3;
  - then (89,F1,02,1);
  - then (42,00,04,0), arriving 3 cycles after the previous transfer.
- Hold `instr_ready`=0 for 5 cycles while (87,F0) is valid → outputs are stable, `mem_addr` does not advance, and the next instruction is 89 after ready rises.
- Pulse `jump_en`, target 0x0B, while (96,80) is being fetched → `instr_valid`=0 next cycle, 96 is never issued, next instruction is (87,F2,pc 0B).
- `jump_en` (target 0x04) in the same cycle as a transfer of (20,04) → the next instruction is at pc 04 (42), not at pc 0F.
- Fill the ROM with 0x00 from 0x0F, `jump_target`=0x7E:
  - 0x7E and 0x7F are issued as 1-byte 00;
  - after the 0x7F transfer, `halted`=1 and `instr_valid`=0;
  - a jump to 0x00 clears `halted` and issues 87.
- Assert `rst_n` low during OPR → outputs return to reset values without waiting for a clock edge; after release, the first instruction is (87,F0,00).
